pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Registered program-counter unit for the MIPS core; next generation of the combinational next-PC mux.
//  Owns the PC register and the exception state (EPC plus RUN/EXC FSM), and adds stall and ERET.
//  Address width, vector and reset address are parametrised; an optional return-address stack is available.
//  Sits between decode/control (pc_sel, branch flags) and instruction memory (pc).
// PARAMETERS
//  PC_W      12     PC/address width in bits
//  DATA_W    32     width of zero-extended pc_plus_1_ext (>= PC_W)
//  RESET_PC  0      PC value loaded on reset
//  EXC_VEC   12'h0  exception vector address (PC_W bits)
//  RAS_DEPTH 4      return-address-stack entries (power of 2, >= 2; used only with PC_RAS_EN)
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       synchronous reset, active-high
//  stall         in   1       1 = hold PC, EPC, FSM and RAS this cycle
//  pc_sel        in   3       next-PC mode select
//  t_addr        in   PC_W    absolute jump target
//  n_off         in   PC_W    branch offset, two's complement
//  rd_addr       in   PC_W    register jump target
//  ilt           in   1       less-than flag
//  neq           in   1       not-equal flag
//  cond_sel      in   1       0 = branch on ilt, 1 = branch on neq
//  excep         in   1       exception request (honoured only in mode 001)
//  pc            out  PC_W    current PC
//  pc_plus_1_ext out  DATA_W  {zeros, pc+1}, combinational from pc
//  epc           out  PC_W    saved exception return address
//  in_exc        out  1       1 while FSM is in EXC
// BEHAVIOUR
//  - Reset: pc=RESET_PC, epc=0, FSM=RUN (in_exc=0), RAS empty; rst overrides stall.
//  - pc updates on every rising edge with stall=0; next value selected by pc_sel; 1-cycle latency.
//  - Arithmetic: p1 = pc+1; br = p1+n_off; both are modulo 2^PC_W and wrap silently (no flag).
//  - Mode 000: t_addr. Mode 010: p1. Mode 100: br. Mode 101: rd_addr.
//  - Mode 011: cond = cond_sel ? neq : ilt; next = cond ? br : p1.
//  - Mode 001 with FSM=RUN and excep=1: pc<=EXC_VEC, epc<=p1, FSM->EXC.
//  - Mode 001 with excep=0, or with FSM=EXC (nested exception dropped, epc kept): next = p1.
//  - Mode 110 (ERET): in EXC, pc<=epc and FSM->RUN; in RUN, treated as p1.
//  - Mode 111: p1 (RAS off); pop behaviour when RAS on (see CONFIGURATION).
//  - FSM has two states, RUN and EXC; only the transitions above exist.
//  - stall=1: pc, epc, FSM and RAS all held; excep in the same cycle is lost (the requester must hold it).
//  - pc_plus_1_ext[PC_W-1:0] = p1, upper bits 0.
// CONFIGURATION
//  PC_RAS_EN defined:
//   - Mode 000 also pushes p1 onto the RAS.
//   - Mode 111 pops: pc<=top. On empty, pc<=p1 and no pop occurs.
//   - Push when full discards the oldest entry (circular buffer), count saturates at RAS_DEPTH.
//   - Stall blocks push and pop. Exception entry and ERET do not touch the RAS.
//   - Extra outputs: ras_empty (1) and ras_full (1), both registered; reset values ras_empty=1, ras_full=0.
//  PC_RAS_EN undefined:
//   - No RAS storage and no ras_* ports; mode 111 = p1.
// TESTING
//  1. rst=1 for 2 cycles, then pc_sel=010 for 3 cycles -> pc = 0, 1, 2, 3; pc_plus_1_ext=32'h4 when pc=3.
//  2. pc=12'h010, pc_sel=011, cond_sel=1, neq=1, n_off=12'hFFC -> pc=12'h00D.
//     Same inputs with neq=0 -> pc=12'h011.
//  3. pc=12'hFFF, pc_sel=010 -> pc=12'h000 (wrap).
//     pc=12'h002, pc_sel=100, n_off=12'hFF0 -> pc=12'hFF3.
//  4. pc=12'h020, pc_sel=001, excep=1 -> pc=EXC_VEC, epc=12'h021, in_exc=1.
//     Second excep -> pc=EXC_VEC+1, epc unchanged.
//     pc_sel=110 -> pc=12'h021, in_exc=0.
//  5. stall=1 for 3 cycles with pc_sel=000, t_addr=12'h123 -> pc, epc, in_exc unchanged.
//     Release stall -> pc=12'h123.
//     rst asserted while in EXC -> pc=RESET_PC, in_exc=0.
//  6. (PC_RAS_EN) 5 calls (mode 000) from pc=1,2,3,4,5 with RAS_DEPTH=4 -> ras_full=1.
//     4 pops return 6, 5, 4, 3; 5th pop -> p1, ras_empty=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Registered program-counter unit for the MIPS core. It owns the PC register,
// the exception return address (EPC) and a two-state RUN/EXC machine. It also
// supports stall and ERET.
//
// Optional feature macro: PC_RAS_EN
//   When this macro is defined, a circular return-address stack is added.
//   Mode 000 pushes pc+1 onto it, and mode 111 pops from it.
//   It also adds two registered status ports, ras_empty and ras_full.
//
// Ports
//   clk           in   1       rising-edge clock
//   rst           in   1       synchronous active-high reset (beats stall)
//   stall         in   1       hold PC, EPC, FSM and RAS this cycle
//   pc_sel        in   3       next-PC mode select
//   t_addr        in   PC_W    absolute jump target
//   n_off         in   PC_W    two's complement branch offset
//   rd_addr       in   PC_W    register jump target
//   ilt           in   1       less-than flag
//   neq           in   1       not-equal flag
//   cond_sel      in   1       0 = branch on ilt, 1 = branch on neq
//   excep         in   1       exception request (mode 001 only)
//   pc            out  PC_W    current PC
//   pc_plus_1_ext out  DATA_W  zero-extended pc+1 (combinational from pc)
//   epc           out  PC_W    saved exception return address
//   in_exc        out  1       high while the FSM is in EXC
//   ras_empty     out  1       (PC_RAS_EN only) stack holds no entries
//   ras_full      out  1       (PC_RAS_EN only) stack holds RAS_DEPTH entries
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              PC_W      = 12,
  parameter int              DATA_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}},
  parameter logic [PC_W-1:0] EXC_VEC   = {PC_W{1'b0}},
  parameter int              RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        pc_sel,
  input  logic [PC_W-1:0]   t_addr,
  input  logic [PC_W-1:0]   n_off,
  input  logic [PC_W-1:0]   rd_addr,
  input  logic              ilt,
  input  logic              neq,
  input  logic              cond_sel,
  input  logic              excep,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] pc_plus_1_ext,
  output logic [PC_W-1:0]   epc,
  output logic              in_exc
`ifdef PC_RAS_EN
  ,
  output logic              ras_empty,
  output logic              ras_full
`endif
);

  // Mode encodings of pc_sel.
  localparam logic [2:0] SEL_JUMP = 3'b000;
  localparam logic [2:0] SEL_EXC  = 3'b001;
  localparam logic [2:0] SEL_SEQ  = 3'b010;
  localparam logic [2:0] SEL_COND = 3'b011;
  localparam logic [2:0] SEL_BR   = 3'b100;
  localparam logic [2:0] SEL_JR   = 3'b101;
  localparam logic [2:0] SEL_ERET = 3'b110;
  localparam logic [2:0] SEL_RET  = 3'b111;

  // Elaboration-time checks for parameter combinations that cannot work.
  if (DATA_W < PC_W) begin : g_bad_data_w
    $error("pc_sequencer: DATA_W must be >= PC_W");
  end
  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_ras_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of two and >= 2");
  end

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] epc_r;
  logic            in_exc_r;
  logic [PC_W-1:0] pc_nxt_s;
  logic [PC_W-1:0] epc_nxt_s;
  logic [PC_W-1:0] p1_s;
  logic [PC_W-1:0] br_s;
  logic            cond_s;

  // Both sums wrap modulo 2^PC_W. No carry is exported.
  assign p1_s   = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  assign br_s   = p1_s + n_off;
  assign cond_s = cond_sel ? neq : ilt;

  assign pc            = pc_r;
  assign epc           = epc_r;
  assign in_exc        = in_exc_r;
  assign pc_plus_1_ext = DATA_W'(p1_s);

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] ras_wp_r;      // next slot to write; top sits one below
  logic [CNT_W-1:0] ras_cnt_r;
  logic             ras_empty_r;
  logic             ras_full_r;
  logic [PTR_W-1:0] ras_top_idx_s;
  logic [PC_W-1:0]  ras_top_s;
  logic             push_req_s;
  logic             pop_req_s;
  logic             push_s;
  logic             pop_s;
  logic [PTR_W-1:0] ras_wp_nxt_s;
  logic [CNT_W-1:0] ras_cnt_nxt_s;

  assign ras_top_idx_s = ras_wp_r - PTR_W'(1'b1);
  assign ras_top_s     = ras_mem_r[ras_top_idx_s];
  // A stalled cycle neither pushes nor pops.
  assign push_s        = push_req_s & ~stall;
  assign pop_s         = pop_req_s & ~stall;
  assign ras_empty     = ras_empty_r;
  assign ras_full      = ras_full_r;
`endif

  // Next-PC, EPC and FSM selection from pc_sel and the current state.
  always_comb begin
    pc_nxt_s    = p1_s;
    epc_nxt_s   = epc_r;
    state_nxt_s = state_r;
`ifdef PC_RAS_EN
    push_req_s  = 1'b0;
    pop_req_s   = 1'b0;
`endif
    case (pc_sel)
      SEL_JUMP: begin
        pc_nxt_s = t_addr;
`ifdef PC_RAS_EN
        push_req_s = 1'b1;
`endif
      end
      SEL_EXC: begin
        // A nested request while in EXC is dropped. EPC keeps the first return address.
        if ((state_r == ST_RUN) && excep) begin
          pc_nxt_s    = EXC_VEC;
          epc_nxt_s   = p1_s;
          state_nxt_s = ST_EXC;
        end else begin
          pc_nxt_s = p1_s;
        end
      end
      SEL_SEQ: begin
        pc_nxt_s = p1_s;
      end
      SEL_COND: begin
        if (cond_s) begin
          pc_nxt_s = br_s;
        end else begin
          pc_nxt_s = p1_s;
        end
      end
      SEL_BR: begin
        pc_nxt_s = br_s;
      end
      SEL_JR: begin
        pc_nxt_s = rd_addr;
      end
      SEL_ERET: begin
        // In RUN there is nothing to return from, so ERET behaves like a plain step.
        if (state_r == ST_EXC) begin
          pc_nxt_s    = epc_r;
          state_nxt_s = ST_RUN;
        end else begin
          pc_nxt_s = p1_s;
        end
      end
      SEL_RET: begin
`ifdef PC_RAS_EN
        // A pop from an empty stack falls through to pc+1 and leaves the stack untouched.
        if (!ras_empty_r) begin
          pc_nxt_s  = ras_top_s;
          pop_req_s = 1'b1;
        end else begin
          pc_nxt_s = p1_s;
        end
`else
        pc_nxt_s = p1_s;
`endif
      end
      default: begin
        pc_nxt_s = p1_s;
      end
    endcase
  end

  // PC, EPC and FSM state registers. rst wins over stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      epc_r    <= {PC_W{1'b0}};
      state_r  <= ST_RUN;
      in_exc_r <= 1'b0;
    end else if (!stall) begin
      pc_r     <= pc_nxt_s;
      epc_r    <= epc_nxt_s;
      state_r  <= state_nxt_s;
      in_exc_r <= (state_nxt_s == ST_EXC);
    end
  end

`ifdef PC_RAS_EN
  // Stack pointer and occupancy update. A push onto a full stack overwrites the oldest entry.
  always_comb begin
    ras_wp_nxt_s  = ras_wp_r;
    ras_cnt_nxt_s = ras_cnt_r;
    if (push_s) begin
      ras_wp_nxt_s = ras_wp_r + PTR_W'(1'b1);
      if (ras_full_r) begin
        ras_cnt_nxt_s = ras_cnt_r;
      end else begin
        ras_cnt_nxt_s = ras_cnt_r + CNT_W'(1'b1);
      end
    end else if (pop_s) begin
      ras_wp_nxt_s  = ras_wp_r - PTR_W'(1'b1);
      ras_cnt_nxt_s = ras_cnt_r - CNT_W'(1'b1);
    end else begin
      ras_wp_nxt_s  = ras_wp_r;
      ras_cnt_nxt_s = ras_cnt_r;
    end
  end

  // Return-address stack storage, pointer, count and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= {PC_W{1'b0}};
      end
      ras_wp_r    <= {PTR_W{1'b0}};
      ras_cnt_r   <= {CNT_W{1'b0}};
      ras_empty_r <= 1'b1;
      ras_full_r  <= 1'b0;
    end else begin
      if (push_s) begin
        ras_mem_r[ras_wp_r] <= p1_s;
      end
      ras_wp_r    <= ras_wp_nxt_s;
      ras_cnt_r   <= ras_cnt_nxt_s;
      ras_empty_r <= (ras_cnt_nxt_s == {CNT_W{1'b0}});
      ras_full_r  <= (ras_cnt_nxt_s == CNT_MAX);
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed scoreboard bench for pc_sequencer.
//
// The driver sets one input vector on each falling edge. At the same time it
// pushes the hand-computed register state expected after the next rising edge.
// A separate monitor samples the outputs 1 ns after each rising edge. It pops
// one expectation and compares against it.
//
// When PC_RAS_EN is defined, the return-address-stack sequence is also run.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [11:0] EXC_VEC = 12'h080;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [2:0]  pc_sel;
  logic [11:0] t_addr;
  logic [11:0] n_off;
  logic [11:0] rd_addr;
  logic        ilt;
  logic        neq;
  logic        cond_sel;
  logic        excep;
  logic [11:0] pc;
  logic [31:0] pc_plus_1_ext;
  logic [11:0] epc;
  logic        in_exc;
`ifdef PC_RAS_EN
  logic        ras_empty;
  logic        ras_full;
`endif

  pc_sequencer #(
    .PC_W(12), .DATA_W(32), .RESET_PC(12'h000), .EXC_VEC(EXC_VEC), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .t_addr(t_addr),
    .n_off(n_off), .rd_addr(rd_addr), .ilt(ilt), .neq(neq), .cond_sel(cond_sel),
    .excep(excep), .pc(pc), .pc_plus_1_ext(pc_plus_1_ext), .epc(epc), .in_exc(in_exc)
`ifdef PC_RAS_EN
    , .ras_empty(ras_empty), .ras_full(ras_full)
`endif
  );

  typedef struct {
    logic [11:0] pc;
    logic [11:0] epc;
    logic        exc;
    logic        chk_ras;
    logic        r_empty;
    logic        r_full;
  } want_t;

  want_t sb_q[$];
  int    n_cmp;
  int    n_err;
  logic  g_chk_ras;
  logic  g_empty;
  logic  g_full;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pop one expectation per rising edge, sampled away from the edge.
  always @(posedge clk) begin
    want_t       w;
    logic [11:0] p1e;
    #1;
    if (sb_q.size() != 0) begin
      w   = sb_q.pop_front();
      p1e = w.pc + 12'd1;
      chk("pc", {20'h0, pc}, {20'h0, w.pc});
      chk("epc", {20'h0, epc}, {20'h0, w.epc});
      chk("in_exc", {31'h0, in_exc}, {31'h0, w.exc});
      chk("pc_plus_1_ext", pc_plus_1_ext, {20'h0, p1e});
`ifdef PC_RAS_EN
      if (w.chk_ras) begin
        chk("ras_empty", {31'h0, ras_empty}, {31'h0, w.r_empty});
        chk("ras_full", {31'h0, ras_full}, {31'h0, w.r_full});
      end
`endif
    end
  end

  // Drive one vector and queue the state expected after the next rising edge.
  task automatic go(input logic r, input logic st, input logic [2:0] sel,
                    input logic [11:0] ta, input logic [11:0] off, input logic [11:0] rd,
                    input logic c_ilt, input logic c_neq, input logic cs, input logic ex,
                    input logic [11:0] e_pc, input logic [11:0] e_epc, input logic e_exc);
    want_t w;
    @(negedge clk);
    rst = r; stall = st; pc_sel = sel; t_addr = ta; n_off = off; rd_addr = rd;
    ilt = c_ilt; neq = c_neq; cond_sel = cs; excep = ex;
    w.pc = e_pc; w.epc = e_epc; w.exc = e_exc;
    w.chk_ras = g_chk_ras; w.r_empty = g_empty; w.r_full = g_full;
    sb_q.push_back(w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    g_chk_ras = 1'b0; g_empty = 1'b1; g_full = 1'b0;
    rst = 1'b1; stall = 1'b0; pc_sel = 3'b010; t_addr = 12'h0; n_off = 12'h0;
    rd_addr = 12'h0; ilt = 1'b0; neq = 1'b0; cond_sel = 1'b0; excep = 1'b0;

    // Reset for 2 cycles, then sequential steps 1, 2 and 3.
    //  rst st  sel     t_addr n_off  rd     ilt   neq   cs    exc     pc      epc     exc
    go(1'b1,1'b0,3'b010,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h000,12'h000,1'b0);
    go(1'b1,1'b0,3'b010,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h000,12'h000,1'b0);
    go(1'b0,1'b0,3'b010,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h001,12'h000,1'b0);
    go(1'b0,1'b0,3'b010,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h002,12'h000,1'b0);
    go(1'b0,1'b0,3'b010,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h003,12'h000,1'b0);
    // Mode 111 with nothing to return to: pc+1.
    go(1'b0,1'b0,3'b111,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h004,12'h000,1'b0);
    // Conditional branch on neq, taken (0x011 + 0xFFC = 0x00D) and not taken.
    go(1'b0,1'b0,3'b000,12'h010,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h010,12'h000,1'b0);
    go(1'b0,1'b0,3'b011,12'h000,12'hFFC,12'h000,1'b0,1'b1,1'b1,1'b0, 12'h00D,12'h000,1'b0);
    go(1'b0,1'b0,3'b000,12'h010,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h010,12'h000,1'b0);
    go(1'b0,1'b0,3'b011,12'h000,12'hFFC,12'h000,1'b0,1'b0,1'b1,1'b0, 12'h011,12'h000,1'b0);
    // Branch on ilt: taken (0x012 + 0x005), then not taken while neq is high.
    go(1'b0,1'b0,3'b011,12'h000,12'h005,12'h000,1'b1,1'b0,1'b0,1'b0, 12'h017,12'h000,1'b0);
    go(1'b0,1'b0,3'b011,12'h000,12'h005,12'h000,1'b0,1'b1,1'b0,1'b0, 12'h018,12'h000,1'b0);
    // Wrap-around of pc+1, and a negative branch that wraps (0x003 + 0xFF0).
    go(1'b0,1'b0,3'b000,12'hFFF,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'hFFF,12'h000,1'b0);
    go(1'b0,1'b0,3'b010,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h000,12'h000,1'b0);
    go(1'b0,1'b0,3'b000,12'h002,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h002,12'h000,1'b0);
    go(1'b0,1'b0,3'b100,12'h000,12'hFF0,12'h000,1'b0,1'b0,1'b0,1'b0, 12'hFF3,12'h000,1'b0);
    // Register jump, ERET while in RUN, mode 001 without a request.
    go(1'b0,1'b0,3'b101,12'h000,12'h000,12'h456,1'b0,1'b0,1'b0,1'b0, 12'h456,12'h000,1'b0);
    go(1'b0,1'b0,3'b110,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h457,12'h000,1'b0);
    go(1'b0,1'b0,3'b001,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h458,12'h000,1'b0);
    // Exception entry, nested exception dropped, ERET, then ERET in RUN.
    go(1'b0,1'b0,3'b000,12'h020,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h020,12'h000,1'b0);
    go(1'b0,1'b0,3'b001,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b1, EXC_VEC,12'h021,1'b1);
    go(1'b0,1'b0,3'b001,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b1, 12'h081,12'h021,1'b1);
    go(1'b0,1'b0,3'b110,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h021,12'h021,1'b0);
    go(1'b0,1'b0,3'b110,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h022,12'h021,1'b0);
    go(1'b0,1'b0,3'b001,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h023,12'h021,1'b0);
    // Enter EXC again, stall 3 cycles on a jump plus one on ERET, then release.
    go(1'b0,1'b0,3'b001,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b1, EXC_VEC,12'h024,1'b1);
    go(1'b0,1'b1,3'b000,12'h123,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, EXC_VEC,12'h024,1'b1);
    go(1'b0,1'b1,3'b000,12'h123,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, EXC_VEC,12'h024,1'b1);
    go(1'b0,1'b1,3'b000,12'h123,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, EXC_VEC,12'h024,1'b1);
    go(1'b0,1'b1,3'b110,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, EXC_VEC,12'h024,1'b1);
    go(1'b0,1'b0,3'b000,12'h123,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h123,12'h024,1'b1);
    // Reset while in EXC, with stall also high.
    g_chk_ras = 1'b1; g_empty = 1'b1; g_full = 1'b0;
    go(1'b1,1'b1,3'b000,12'h123,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h000,12'h000,1'b0);
    // An exception request during stall is lost.
    go(1'b0,1'b1,3'b001,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b1, 12'h000,12'h000,1'b0);
    go(1'b0,1'b0,3'b010,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h001,12'h000,1'b0);

`ifdef PC_RAS_EN
    // Five calls from pc = 1..5. The oldest return address (2) is discarded.
    g_empty = 1'b0; g_full = 1'b0;
    go(1'b0,1'b0,3'b000,12'h002,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h002,12'h000,1'b0);
    go(1'b0,1'b0,3'b000,12'h003,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h003,12'h000,1'b0);
    go(1'b0,1'b0,3'b000,12'h004,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h004,12'h000,1'b0);
    g_full = 1'b1;
    go(1'b0,1'b0,3'b000,12'h005,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h005,12'h000,1'b0);
    go(1'b0,1'b0,3'b000,12'h006,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h006,12'h000,1'b0);
    // A stalled pop has no effect.
    go(1'b0,1'b1,3'b111,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h006,12'h000,1'b0);
    g_full = 1'b0;
    go(1'b0,1'b0,3'b111,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h006,12'h000,1'b0);
    go(1'b0,1'b0,3'b111,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h005,12'h000,1'b0);
    go(1'b0,1'b0,3'b111,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h004,12'h000,1'b0);
    g_empty = 1'b1;
    go(1'b0,1'b0,3'b111,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h003,12'h000,1'b0);
    go(1'b0,1'b0,3'b111,12'h000,12'h000,12'h000,1'b0,1'b0,1'b0,1'b0, 12'h004,12'h000,1'b0);
`endif

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
